pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage directly upstream of the instruction decoder. It owns the PC, drives the synchronous instruction SRAM, and presents one 16-bit instruction per cycle to the decoder's `instruction` input. It also consumes the decoder's `bcond`/`jcond`/`jal`/`disp`/`stall` outputs to redirect the PC, squash the wrong-path fetch, and supply the JAL link address.

---
 rtl/pc_fetch_unit.sv | 106 ++++++++++
 tb/tb_pc_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// PC and instruction-fetch stage: owns the PC, drives the synchronous instruction SRAM,
// feeds the decoder one instruction per cycle and handles branch/jump redirects.
module pc_fetch_unit #(
  parameter int unsigned          PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [15:0]          NOP_INSTR = 16'h4FC0
) (
  input  logic                clk,
  input  logic                global_reset,
  input  logic                bcond,
  input  logic                jcond,
  input  logic                jal,
  input  logic [7:0]          disp,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                stall,
  input  logic [15:0]         imem_q,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_ceb,
  output logic [15:0]         instruction,
  output logic [PC_WIDTH-1:0] pc_d,
  output logic [PC_WIDTH-1:0] link_addr
);

  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_SQUASH
  } state_t;

  state_t               state, state_n;
  logic [PC_WIDTH-1:0]  pc, pc_n;
  logic [PC_WIDTH-1:0]  pc_d_n;
  logic [INSTR_W-1:0]   instr_n;
  logic [PC_WIDTH-1:0]  target_c;
  logic                 redirect_c;

  // Redirect target: jal/jcond use the register value, bcond is PC-relative.
  always_comb begin
    target_c = pc_d + PC_WIDTH'($signed(disp));
    if (jal || jcond) begin
      target_c = jump_target;
    end
  end

  // State register and fetch pipeline registers.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      pc_d        <= RESET_PC;
      instruction <= NOP_INSTR;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pc_d        <= pc_d_n;
      instruction <= instr_n;
    end
  end

  // Next-state and next-value logic; stall simply keeps the defaults.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pc_d_n     = pc_d;
    instr_n    = instruction;
    redirect_c = 1'b0;
    if (!stall) begin
      unique case (state)
        S_BOOT: begin
          state_n = S_RUN;
          pc_n    = pc + PC_WIDTH'(1);
        end
        S_RUN: begin
          if (jal || jcond || bcond) begin
            redirect_c = 1'b1;
            state_n    = S_SQUASH;
            pc_n       = target_c + PC_WIDTH'(1);
            pc_d_n     = target_c;
            instr_n    = NOP_INSTR;
          end else begin
            pc_n    = pc + PC_WIDTH'(1);
            pc_d_n  = pc - PC_WIDTH'(1);
            instr_n = imem_q;
          end
        end
        S_SQUASH: begin
          state_n = S_RUN;
          pc_n    = pc + PC_WIDTH'(1);
          pc_d_n  = pc - PC_WIDTH'(1);
          instr_n = imem_q;
        end
        default: begin
          state_n = S_BOOT;
        end
      endcase
    end
  end

  // The redirect target is presented to the SRAM in the same cycle the redirect is seen.
  assign imem_addr = redirect_c ? target_c : pc;
  assign imem_ceb  = global_reset | stall;
  assign link_addr = pc_d + PC_WIDTH'(1);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: SRAM model plus a queue of expected decoder-side outputs.
module tb_pc_fetch_unit;

  localparam logic [15:0] NOP = 16'h4FC0;

  logic        clk = 1'b0;
  logic        global_reset;
  logic        bcond, jcond, jal, stall;
  logic [7:0]  disp;
  logic [15:0] jump_target;
  logic [15:0] imem_q;
  logic [15:0] imem_addr;
  logic        imem_ceb;
  logic [15:0] instruction;
  logic [15:0] pc_d;
  logic [15:0] link_addr;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pcd;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [65536];
  int          checks = 0;
  int          failures = 0;

  pc_fetch_unit dut (
    .clk          (clk),
    .global_reset (global_reset),
    .bcond        (bcond),
    .jcond        (jcond),
    .jal          (jal),
    .disp         (disp),
    .jump_target  (jump_target),
    .stall        (stall),
    .imem_q       (imem_q),
    .imem_addr    (imem_addr),
    .imem_ceb     (imem_ceb),
    .instruction  (instruction),
    .pc_d         (pc_d),
    .link_addr    (link_addr)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: output updates only on enabled cycles, otherwise holds.
  always @(posedge clk) begin
    if (!imem_ceb) imem_q <= mem[imem_addr];
  end

  function automatic logic [15:0] memval(input logic [15:0] a);
    return 16'(16'h5100 + a);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] i, input logic [15:0] p);
    exp_t e;
    e.instr = i;
    e.pcd   = p;
    sb.push_back(e);
  endtask

  // Advance one clock and compare against the oldest queued expectation.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("instruction", instruction, e.instr);
      chk("pc_d", pc_d, e.pcd);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = memval(16'(i));
    global_reset = 1'b1;
    bcond = 1'b0; jcond = 1'b0; jal = 1'b0; stall = 1'b0;
    disp = 8'h00; jump_target = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instruction", instruction, NOP);
    chk("rst_pc_d", pc_d, 16'h0000);
    chk("rst_ceb", 16'(imem_ceb), 16'h0001);
    chk("rst_addr", imem_addr, 16'h0000);

    // Reset release: BOOT, one NOP cycle, then sequential fetch
    global_reset = 1'b0;
    #1;
    chk("boot_ceb", 16'(imem_ceb), 16'h0000);
    chk("boot_addr", imem_addr, 16'h0000);
    push(NOP, 16'h0000); cyc();
    push(16'h5100, 16'h0000); cyc();
    push(16'h5101, 16'h0001); cyc();
    for (int k = 2; k <= 10; k++) begin
      push(memval(16'(k)), 16'(k)); cyc();
    end

    // bcond with disp=-4 from pc_d=10
    bcond = 1'b1; disp = 8'hFC;
    #1;
    chk("bcond_addr", imem_addr, 16'h0006);
    push(NOP, 16'h0006); cyc();
    bcond = 1'b0;
    #1;
    chk("squash_addr", imem_addr, 16'h0007);
    push(memval(16'h0006), 16'h0006); cyc();
    push(memval(16'h0007), 16'h0007); cyc();

    // jal: link address is pc_d+1 in the same cycle
    jal = 1'b1; jump_target = 16'h0040;
    #1;
    chk("jal_link", link_addr, 16'h0008);
    chk("jal_addr", imem_addr, 16'h0040);
    push(NOP, 16'h0040); cyc();
    jal = 1'b0; bcond = 1'b1; disp = 8'h10;
    #1;
    chk("squash_ignores_bcond", imem_addr, 16'h0041);
    push(memval(16'h0040), 16'h0040); cyc();
    bcond = 1'b0;
    push(memval(16'h0041), 16'h0041); cyc();

    // jcond beats bcond
    jcond = 1'b1; bcond = 1'b1; jump_target = 16'h0020; disp = 8'h05;
    #1;
    chk("jcond_prio_addr", imem_addr, 16'h0020);
    push(NOP, 16'h0020); cyc();
    jcond = 1'b0; bcond = 1'b0;
    push(memval(16'h0020), 16'h0020); cyc();
    push(memval(16'h0021), 16'h0021); cyc();

    // stall for 3 cycles with bcond (disp=-128) pending
    stall = 1'b1; bcond = 1'b1; disp = 8'h80;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ceb", 16'(imem_ceb), 16'h0001);
      push(memval(16'h0021), 16'h0021); cyc();
    end
    stall = 1'b0;
    #1;
    chk("release_ceb", 16'(imem_ceb), 16'h0000);
    chk("release_addr", imem_addr, 16'hFFA1);
    push(NOP, 16'hFFA1); cyc();
    bcond = 1'b0;
    push(memval(16'hFFA1), 16'hFFA1); cyc();
    push(memval(16'hFFA2), 16'hFFA2); cyc();

    // PC wrap from 0xFFFF to 0
    jal = 1'b1; jump_target = 16'hFFFF;
    #1;
    chk("wrap_link", link_addr, 16'hFFA3);
    push(NOP, 16'hFFFF); cyc();
    jal = 1'b0;
    push(memval(16'hFFFF), 16'hFFFF); cyc();
    push(16'h5100, 16'h0000); cyc();
    push(16'h5101, 16'h0001); cyc();

    // Maximum positive displacement
    bcond = 1'b1; disp = 8'h7F;
    #1;
    chk("disp_max_addr", imem_addr, 16'h0080);
    push(NOP, 16'h0080); cyc();
    bcond = 1'b0;
    push(memval(16'h0080), 16'h0080); cyc();

    // Asynchronous reset pulsed in the middle of a SQUASH cycle
    jal = 1'b1; jump_target = 16'h0030;
    push(NOP, 16'h0030); cyc();
    jal = 1'b0;
    #2;
    global_reset = 1'b1;
    #1;
    chk("async_rst_instruction", instruction, NOP);
    chk("async_rst_pc_d", pc_d, 16'h0000);
    chk("async_rst_ceb", 16'(imem_ceb), 16'h0001);
    chk("async_rst_addr", imem_addr, 16'h0000);
    #2;
    global_reset = 1'b0;
    push(NOP, 16'h0000); cyc();
    push(16'h5100, 16'h0000); cyc();
    push(16'h5101, 16'h0001); cyc();

    chk("scoreboard_drained", 16'(sb.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
